// File: rtl/y86_writeback_stage_if.sv
// rtl/y86_writeback_stage_if.sv - memory-to-writeback pipeline bundle and register-file/forwarding taps
interface y86_writeback_stage_if;
  logic [2:0]  m_stat;
  logic [3:0]  m_icode;
  logic [63:0] m_valE;
  logic [63:0] m_valM;
  logic [3:0]  m_dstE;
  logic [3:0]  m_dstM;
  logic        w_stall;
  logic        w_bubble;

  logic [3:0]  registernumber1;
  logic [3:0]  registernumber2;
  logic [63:0] val_write1;
  logic [63:0] val_write2;
  logic        wrEn;
  logic [3:0]  W_dstE;
  logic [3:0]  W_dstM;
  logic [63:0] W_valE;
  logic [63:0] W_valM;
  logic [3:0]  W_icode;
  logic [2:0]  cpu_stat;
  logic        halted;

  modport master (
    output m_stat, m_icode, m_valE, m_valM, m_dstE, m_dstM, w_stall, w_bubble,
    input  registernumber1, registernumber2, val_write1, val_write2, wrEn,
           W_dstE, W_dstM, W_valE, W_valM, W_icode, cpu_stat, halted
  );

  modport slave (
    input  m_stat, m_icode, m_valE, m_valM, m_dstE, m_dstM, w_stall, w_bubble,
    output registernumber1, registernumber2, val_write1, val_write2, wrEn,
           W_dstE, W_dstM, W_valE, W_valM, W_icode, cpu_stat, halted
  );
endinterface

// File: rtl/y86_writeback_stage.sv
// rtl/y86_writeback_stage.sv - Y86-64 W pipeline register, register-file write port and halt FSM
// Optional retired-instruction counter enabled by defining WB_RETIRE_COUNT_EN.
module y86_writeback_stage (
  input  logic                  clk,
  input  logic                  reset,
  y86_writeback_stage_if.slave  wb
`ifdef WB_RETIRE_COUNT_EN
  ,
  output logic [63:0]           retired
`endif
);

  localparam logic [2:0] STAT_BUB = 3'd0;
  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;
  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [3:0] I_NOP    = 4'h1;

  typedef enum logic {RUN, HALTED} state_t;

  state_t      state;
  logic [2:0]  halt_stat;
  logic [2:0]  w_stat;
  logic [3:0]  w_icode;
  logic [63:0] w_valE;
  logic [63:0] w_valM;
  logic [3:0]  w_dstE;
  logic [3:0]  w_dstM;

  logic w_advance;
  logic stop_now;
  logic write_en;
  logic same_dst;

  assign w_advance = (state == RUN) && !wb.w_stall;
  assign stop_now  = (state == RUN) &&
                     ((w_stat == STAT_HLT) || (w_stat == STAT_ADR) || (w_stat == STAT_INS));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      halt_stat <= STAT_AOK;
      w_stat    <= STAT_BUB;
      w_icode   <= I_NOP;
      w_valE    <= 64'd0;
      w_valM    <= 64'd0;
      w_dstE    <= REG_NONE;
      w_dstM    <= REG_NONE;
    end else begin
      if (w_advance) begin
        if (wb.w_bubble) begin
          w_stat  <= STAT_BUB;
          w_icode <= I_NOP;
          w_valE  <= 64'd0;
          w_valM  <= 64'd0;
          w_dstE  <= REG_NONE;
          w_dstM  <= REG_NONE;
        end else begin
          w_stat  <= wb.m_stat;
          w_icode <= wb.m_icode;
          w_valE  <= wb.m_valE;
          w_valM  <= wb.m_valM;
          w_dstE  <= wb.m_dstE;
          w_dstM  <= wb.m_dstM;
        end
      end
      // The faulting status is latched here because W may still take one more load on this edge.
      if (stop_now) begin
        state     <= HALTED;
        halt_stat <= w_stat;
      end
    end
  end

`ifdef WB_RETIRE_COUNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired <= 64'd0;
    end else if (w_advance && ((w_stat == STAT_AOK) || (w_stat == STAT_HLT))) begin
      retired <= retired + 64'd1;
    end
  end
`endif

  assign write_en = (state == RUN) && (w_stat == STAT_AOK) &&
                    ((w_dstE != REG_NONE) || (w_dstM != REG_NONE));
  // popq %rsp: both ports target the same register, the loaded value on the M port wins.
  assign same_dst = (w_dstE == w_dstM) && (w_dstE != REG_NONE);

  assign wb.wrEn            = write_en;
  assign wb.registernumber1 = same_dst ? REG_NONE : w_dstE;
  assign wb.registernumber2 = w_dstM;
  assign wb.val_write1      = w_valE;
  assign wb.val_write2      = w_valM;
  assign wb.W_dstE          = write_en ? w_dstE : REG_NONE;
  assign wb.W_dstM          = write_en ? w_dstM : REG_NONE;
  assign wb.W_valE          = w_valE;
  assign wb.W_valM          = w_valM;
  assign wb.W_icode         = w_icode;
  assign wb.halted          = (state == HALTED);
  assign wb.cpu_stat        = (state == HALTED) ? halt_stat :
                              ((w_stat == STAT_BUB) || (w_stat == STAT_AOK)) ? STAT_AOK : w_stat;

endmodule

// File: tb/tb_y86_writeback_stage.sv
// tb/tb_y86_writeback_stage.sv - scoreboard bench for y86_writeback_stage (WB_RETIRE_COUNT_EN aware)
module tb_y86_writeback_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [63:0] retired_w;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  y86_writeback_stage_if wb_if ();

`ifdef WB_RETIRE_COUNT_EN
  y86_writeback_stage dut (.clk(clk), .reset(rst_n), .wb(wb_if), .retired(retired_w));
`else
  y86_writeback_stage dut (.clk(clk), .reset(rst_n), .wb(wb_if));
  assign retired_w = 64'd0;
`endif

  typedef struct {
    int          tag;
    string       name;
    logic [3:0]  rn1, rn2;
    logic [63:0] ve, vm;
    logic        wren;
    logic [3:0]  wde, wdm, ic;
    logic [2:0]  cs;
    logic        hl;
    logic [63:0] ret;
  } exp_t;

  exp_t sb[$];

  task automatic drive(input logic [2:0] st, input logic [3:0] ic, input logic [3:0] de,
                       input logic [3:0] dm, input logic [63:0] ve, input logic [63:0] vm,
                       input logic stall, input logic bubble);
    wb_if.m_stat   = st;
    wb_if.m_icode  = ic;
    wb_if.m_dstE   = de;
    wb_if.m_dstM   = dm;
    wb_if.m_valE   = ve;
    wb_if.m_valM   = vm;
    wb_if.w_stall  = stall;
    wb_if.w_bubble = bubble;
  endtask

  task automatic put(input logic [2:0] st, input logic [3:0] ic, input logic [3:0] de,
                     input logic [3:0] dm, input logic [63:0] ve, input logic [63:0] vm,
                     input logic stall, input logic bubble);
    @(posedge clk);
    #1;
    drive(st, ic, de, dm, ve, vm, stall, bubble);
  endtask

  task automatic expect_out(input string nm, input int lag, input logic [3:0] rn1, input logic [3:0] rn2,
                            input logic [63:0] ve, input logic [63:0] vm, input logic wren,
                            input logic [3:0] wde, input logic [3:0] wdm, input logic [3:0] ic,
                            input logic [2:0] cs, input logic hl, input logic [63:0] ret);
    exp_t e;
    e.tag = cyc + lag; e.name = nm;
    e.rn1 = rn1; e.rn2 = rn2; e.ve = ve; e.vm = vm; e.wren = wren;
    e.wde = wde; e.wdm = wdm; e.ic = ic; e.cs = cs; e.hl = hl; e.ret = ret;
    sb.push_back(e);
  endtask

  task automatic expect_reset(input string nm, input int lag);
    expect_out(nm, lag, 4'hF, 4'hF, 64'd0, 64'd0, 1'b0, 4'hF, 4'hF, 4'h1, 3'd1, 1'b0, 64'd0);
  endtask

  // Monitor: compares the DUT outputs against every scoreboard entry due in this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].tag <= cyc) begin
      exp_t e;
      logic ok;
      e = sb.pop_front();
      checks++;
      ok = (e.tag == cyc) &&
           (wb_if.registernumber1 == e.rn1) && (wb_if.registernumber2 == e.rn2) &&
           (wb_if.val_write1 == e.ve) && (wb_if.val_write2 == e.vm) &&
           (wb_if.W_valE == e.ve) && (wb_if.W_valM == e.vm) &&
           (wb_if.wrEn == e.wren) && (wb_if.W_dstE == e.wde) && (wb_if.W_dstM == e.wdm) &&
           (wb_if.W_icode == e.ic) && (wb_if.cpu_stat == e.cs) && (wb_if.halted == e.hl);
`ifdef WB_RETIRE_COUNT_EN
      ok = ok && (retired_w == e.ret);
`endif
      if (!ok) begin
        errors++;
        $display("FAIL %s (cyc %0d tag %0d): got rn1=%h rn2=%h vw1=%h vw2=%h WvE=%h WvM=%h wrEn=%b WdE=%h WdM=%h ic=%h stat=%0d halted=%b retired=%0d; want rn1=%h rn2=%h vE=%h vM=%h wrEn=%b WdE=%h WdM=%h ic=%h stat=%0d halted=%b retired=%0d",
                 e.name, cyc, e.tag, wb_if.registernumber1, wb_if.registernumber2, wb_if.val_write1,
                 wb_if.val_write2, wb_if.W_valE, wb_if.W_valM, wb_if.wrEn, wb_if.W_dstE, wb_if.W_dstM,
                 wb_if.W_icode, wb_if.cpu_stat, wb_if.halted, retired_w,
                 e.rn1, e.rn2, e.ve, e.vm, e.wren, e.wde, e.wdm, e.ic, e.cs, e.hl, e.ret);
      end
    end
  end

  initial begin
    drive(3'd1, 4'h3, 4'd6, 4'hF, 64'd100, 64'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    expect_reset("reset_state", 0);
    #2 rst_n = 1'b1;
    expect_out("irmovq", 1, 4'd6, 4'hF, 64'd100, 64'd0, 1'b1, 4'd6, 4'hF, 4'h3, 3'd1, 1'b0, 64'd0);

    put(3'd1, 4'hB, 4'd4, 4'd4, 64'd88, 64'd120, 1'b0, 1'b0);
    expect_out("popq_rsp", 1, 4'hF, 4'd4, 64'd88, 64'd120, 1'b1, 4'd4, 4'd4, 4'hB, 3'd1, 1'b0, 64'd1);

    put(3'd1, 4'h6, 4'd3, 4'hF, 64'd7, 64'd0, 1'b1, 1'b1);
    expect_out("stall_bubble_1", 1, 4'hF, 4'd4, 64'd88, 64'd120, 1'b1, 4'd4, 4'd4, 4'hB, 3'd1, 1'b0, 64'd1);
    put(3'd1, 4'h6, 4'd5, 4'hF, 64'd9, 64'd0, 1'b1, 1'b1);
    expect_out("stall_bubble_2", 1, 4'hF, 4'd4, 64'd88, 64'd120, 1'b1, 4'd4, 4'd4, 4'hB, 3'd1, 1'b0, 64'd1);

    put(3'd1, 4'h6, 4'd5, 4'hF, 64'd9, 64'd0, 1'b0, 1'b1);
    expect_out("bubble", 1, 4'hF, 4'hF, 64'd0, 64'd0, 1'b0, 4'hF, 4'hF, 4'h1, 3'd1, 1'b0, 64'd2);

    put(3'd1, 4'h6, 4'd3, 4'hF, 64'd55, 64'd0, 1'b0, 1'b0);
    expect_out("opq", 1, 4'd3, 4'hF, 64'd55, 64'd0, 1'b1, 4'd3, 4'hF, 4'h6, 3'd1, 1'b0, 64'd2);

    put(3'd1, 4'h5, 4'hF, 4'd7, 64'h40, 64'hDEADBEEFCAFEF00D, 1'b0, 1'b0);
    expect_out("mrmovq", 1, 4'hF, 4'd7, 64'h40, 64'hDEADBEEFCAFEF00D, 1'b1, 4'hF, 4'd7, 4'h5, 3'd1, 1'b0, 64'd3);

    put(3'd1, 4'h7, 4'hF, 4'hF, 64'd9, 64'd0, 1'b0, 1'b0);
    expect_out("no_dst", 1, 4'hF, 4'hF, 64'd9, 64'd0, 1'b0, 4'hF, 4'hF, 4'h7, 3'd1, 1'b0, 64'd4);

    put(3'd3, 4'h5, 4'd2, 4'hF, 64'h1000, 64'd0, 1'b0, 1'b0);
    expect_out("adr_no_write", 1, 4'd2, 4'hF, 64'h1000, 64'd0, 1'b0, 4'hF, 4'hF, 4'h5, 3'd3, 1'b0, 64'd5);

    put(3'd1, 4'h3, 4'd1, 4'hF, 64'd11, 64'd0, 1'b0, 1'b0);
    expect_out("adr_halted", 1, 4'd1, 4'hF, 64'd11, 64'd0, 1'b0, 4'hF, 4'hF, 4'h3, 3'd3, 1'b1, 64'd5);
    put(3'd1, 4'h3, 4'd2, 4'hF, 64'd22, 64'd0, 1'b0, 1'b1);
    expect_out("halted_frozen", 1, 4'd1, 4'hF, 64'd11, 64'd0, 1'b0, 4'hF, 4'hF, 4'h3, 3'd3, 1'b1, 64'd5);

    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    expect_reset("async_reset_halted", 0);
    drive(3'd1, 4'h3, 4'd0, 4'hF, 64'd1, 64'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    expect_reset("reset_held", 0);
    #2 rst_n = 1'b1;
    expect_out("aok_1", 1, 4'd0, 4'hF, 64'd1, 64'd0, 1'b1, 4'd0, 4'hF, 4'h3, 3'd1, 1'b0, 64'd0);

    put(3'd1, 4'h3, 4'd1, 4'hF, 64'd2, 64'd0, 1'b0, 1'b0);
    expect_out("aok_2", 1, 4'd1, 4'hF, 64'd2, 64'd0, 1'b1, 4'd1, 4'hF, 4'h3, 3'd1, 1'b0, 64'd1);
    put(3'd1, 4'h3, 4'd2, 4'hF, 64'd3, 64'd0, 1'b0, 1'b0);
    expect_out("aok_3", 1, 4'd2, 4'hF, 64'd3, 64'd0, 1'b1, 4'd2, 4'hF, 4'h3, 3'd1, 1'b0, 64'd2);
    put(3'd1, 4'h3, 4'd7, 4'hF, 64'd77, 64'd0, 1'b0, 1'b1);
    expect_out("bubble_2", 1, 4'hF, 4'hF, 64'd0, 64'd0, 1'b0, 4'hF, 4'hF, 4'h1, 3'd1, 1'b0, 64'd3);
    put(3'd2, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0, 1'b0, 1'b0);
    expect_out("hlt_in_w", 1, 4'hF, 4'hF, 64'd0, 64'd0, 1'b0, 4'hF, 4'hF, 4'h0, 3'd2, 1'b0, 64'd3);
    put(3'd1, 4'h3, 4'd5, 4'hF, 64'd9, 64'd0, 1'b0, 1'b0);
    expect_out("hlt_halted", 1, 4'd5, 4'hF, 64'd9, 64'd0, 1'b0, 4'hF, 4'hF, 4'h3, 3'd2, 1'b1, 64'd4);
    put(3'd1, 4'h3, 4'd6, 4'hF, 64'd10, 64'd0, 1'b0, 1'b0);
    expect_out("hlt_frozen", 1, 4'd5, 4'hF, 64'd9, 64'd0, 1'b0, 4'hF, 4'hF, 4'h3, 3'd2, 1'b1, 64'd4);

    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    expect_reset("async_reset_2", 0);
    drive(3'd4, 4'hE, 4'd3, 4'd4, 64'd5, 64'd6, 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    expect_out("ins_no_write", 1, 4'd3, 4'd4, 64'd5, 64'd6, 1'b0, 4'hF, 4'hF, 4'hE, 3'd4, 1'b0, 64'd0);
    put(3'd1, 4'h3, 4'd1, 4'hF, 64'd1, 64'd0, 1'b0, 1'b1);
    expect_out("ins_halted", 1, 4'hF, 4'hF, 64'd0, 64'd0, 1'b0, 4'hF, 4'hF, 4'h1, 3'd4, 1'b1, 64'd0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/y86_writeback_stage.md
Y86_WRITEBACK_STAGE -- requirements
Module: y86_writeback_stage

Interface
REQ-001 SHALL provide: clk  in  1  rising-edge clock.
REQ-002 SHALL provide: reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL provide: m_stat  in  3  memory-stage status (0 BUB, 1 AOK, 2 HLT, 3 ADR, 4 INS).
REQ-004 SHALL provide: m_icode  in  4  memory-stage opcode high nibble.
REQ-005 SHALL provide: m_valE, m_valM  in  64 each  ALU result, memory read data.
REQ-006 SHALL provide: m_dstE, m_dstM  in  4 each  destination registers; 4'hF = none.
REQ-007 SHALL provide: w_stall, w_bubble  in  1 each  pipeline control.
REQ-008 SHALL provide: registernumber1, registernumber2  out  4 each  register-file write addresses (E port, M port).
REQ-009 SHALL provide: val_write1, val_write2  out  64 each  register-file write data.
REQ-010 SHALL provide: wrEn  out  1  register-file write enable.
REQ-011 SHALL provide: W_dstE, W_dstM  out  4 each; W_valE, W_valM  out  64 each  forwarding taps.
REQ-012 SHALL provide: cpu_stat  out  3  architectural status; halted  out  1  sticky stop flag.

Function
REQ-013 SHALL hold a W register (stat, icode, valE, valM, dstE, dstM) loaded from m_* on each rising clk when w_stall=0 and w_bubble=0.
REQ-014 w_stall=1 SHALL hold W unchanged; stall SHALL take priority over a simultaneous w_bubble.
REQ-015 w_bubble=1 (w_stall=0) SHALL load stat=BUB, icode=1 (nop), dstE=dstM=F, valE=valM=0.
REQ-016 Forwarding taps SHALL equal the W register contents combinationally; W_dstE/W_dstM SHALL read F whenever wrEn would be 0.
REQ-017 registernumber1=W.dstE, registernumber2=W.dstM, val_write1=W.valE, val_write2=W.valM, all combinational from W.
REQ-018 wrEn SHALL be 1 only in state RUN with W.stat=AOK and at least one of dstE, dstM not F.
REQ-019 If W.dstE=W.dstM (not F), registernumber1 SHALL be driven to F so the M port alone writes that register (popq %rsp semantics).
REQ-020 FSM: RUN and HALTED; RUN->HALTED on the rising clk while W.stat is HLT, ADR or INS; HALTED is left only by reset.
REQ-021 In HALTED, W SHALL freeze regardless of w_stall/w_bubble; wrEn=0; halted=1.
REQ-022 cpu_stat SHALL be AOK while W.stat is BUB or AOK in RUN, else W.stat; in HALTED it SHALL hold the status that caused the halt.
REQ-023 ADR/INS instructions SHALL perform no register write even if dst fields are valid.

Reset
REQ-024 reset=0 SHALL asynchronously force W to the bubble values, FSM to RUN, cpu_stat=AOK, halted=0, wrEn=0, all write addresses F, all data outputs 0.
REQ-025 Reset asserted mid-operation SHALL discard the W contents; the first load after deassertion SHALL occur at the next rising clk.

Configuration
REQ-026 With WB_RETIRE_COUNT_EN defined, output retired (64-bit) SHALL increment by 1 at each rising clk where state=RUN, W is not stalled, and W.stat is AOK or HLT; reset clears it; wraps modulo 2^64.
REQ-027 Without WB_RETIRE_COUNT_EN, the retired port and counter SHALL be absent.

Verification
REQ-028 irmovq: m_stat=1, dstE=6, valE=100 then clk -> wrEn=1, registernumber1=6, val_write1=100, registernumber2=F.
REQ-029 popq %rsp: dstE=4, dstM=4, valE=88, valM=120 -> registernumber1=F, registernumber2=4, val_write2=120, wrEn=1.
REQ-030 w_stall=1 and w_bubble=1 together for 2 cycles with new m_* -> W, outputs unchanged; then w_bubble alone -> wrEn=0, W_dstE=W_dstM=F.
REQ-031 m_stat=3 (ADR), dstE=2 -> wrEn=0, next clk halted=1, cpu_stat=3; subsequent AOK inputs produce no writes.
REQ-032 reset=0 asynchronously between clock edges while halted -> halted=0, cpu_stat=1, wrEn=0 immediately; retired=0 when WB_RETIRE_COUNT_EN is defined.
REQ-033 WB_RETIRE_COUNT_EN: 3 AOK, 1 bubble, 1 HLT retired -> retired=4, halted=1.
